// File: rtl/chunked_ripple_adder.sv
// Purpose:      multi-cycle WIDTH-bit adder (a + b + c_in), CHUNK bits per cycle, ripple carry kept in a register.
// Latency:      result valid NCHUNK cycles after the accept edge; one op per NCHUNK+2 cycles at best.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, and no new op is taken meanwhile.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      operand handshake; a, b, c_in are captured on accept
//   out_valid / out_ready    result handshake; s, c_out (and ovf) are registered and stable while out_valid is high
//   ovf                      signed overflow flag, present only when ADD_OVF_FLAG_EN is defined
//
// Build option: define ADD_OVF_FLAG_EN to add the ovf output and its logic.
module chunked_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef ADD_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("chunked_ripple_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // One chunk of the ripple: the only carry chain is CHUNK bits long.
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;

    assign a_chunk   = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign b_chunk   = b_q[int'(idx_q) * CHUNK +: CHUNK];
    assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

`ifdef ADD_OVF_FLAG_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        idx_d   = idx_q;
`ifdef ADD_OVF_FLAG_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    s_d     = '0;
`ifdef ADD_OVF_FLAG_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[int'(idx_q) * CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d = chunk_sum[CHUNK];
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    c_out_d = chunk_sum[CHUNK];
`ifdef ADD_OVF_FLAG_EN
                    // The last chunk holds the sum MSB, so its top bit is the final sign.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            idx_q   <= '0;
`ifdef ADD_OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            idx_q   <= idx_d;
`ifdef ADD_OVF_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign c_out     = c_out_q;
`ifdef ADD_OVF_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_ripple_adder.sv
// Purpose:      self-checking bench for chunked_ripple_adder (16/4 instance plus an 8/8 single-pass instance).
// Latency:      checks the accept-to-out_valid delay and the hold behaviour in DONE.
// Backpressure: drives random in_valid / out_ready gaps against a queue-based reference model.
module tb_chunked_ripple_adder;

    localparam int NRAND = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        c_out;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        c_in8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  s8;
    logic        c_out8;

`ifdef ADD_OVF_FLAG_EN
    logic        ovf;
    logic        ovf8;
`endif

    int n_total = 0;
    int n_bad   = 0;

    logic [16:0] exp_sum_q[$];
    bit          exp_ovf_q[$];

    always #5 clk = ~clk;

    chunked_ripple_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out)
`ifdef ADD_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    chunked_ripple_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .c_in      (c_in8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .s         (s8),
        .c_out     (c_out8)
`ifdef ADD_OVF_FLAG_EN
        ,
        .ovf       (ovf8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Signed overflow from plain integer arithmetic on the 16-bit operands.
    function automatic bit ref_ovf16(input logic [15:0] x, input logic [15:0] y, input logic ci);
        int sx;
        sx = int'($signed(x)) + int'($signed(y)) + int'(ci);
        return (sx > 32767) || (sx < -32768);
    endfunction

    // Present operands and hold in_valid until the DUT takes them (bounded).
    task automatic send_op(input logic [15:0] x, input logic [15:0] y, input logic ci);
        bit rdy;
        bit done;
        a        = x;
        b        = y;
        c_in     = ci;
        in_valid = 1'b1;
        done     = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            rdy = in_ready;
            tick();
            if (rdy) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_result();
        bit seen;
        seen = out_valid;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            seen = out_valid;
        end
        if (!seen) check("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [15:0] x, input logic [15:0] y, input logic ci);
        logic [16:0] want;
        want = {1'b0, x} + {1'b0, y} + {16'd0, ci};
        send_op(x, y, ci);
        wait_result();
        check({tag, "_sum"}, {15'd0, c_out, s}, {15'd0, want});
`ifdef ADD_OVF_FLAG_EN
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, ref_ovf16(x, y, ci)});
`endif
    endtask

    initial begin
        logic [16:0] held;
        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        c_in       = 1'b0;
        out_ready  = 1'b0;
        in_valid8  = 1'b0;
        a8         = '0;
        b8         = '0;
        c_in8      = 1'b0;
        out_ready8 = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_s",         {16'd0, s},         32'd0);
        check("rst_c_out",     {31'd0, c_out},     32'd0);
        check("rst8_in_ready", {31'd0, in_ready8}, 32'd1);
`ifdef ADD_OVF_FLAG_EN
        check("rst_ovf",       {31'd0, ovf},       32'd0);
`endif

        // FFFF + 0001: wrap with carry out; out_valid exactly 4 cycles after accept
        a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("lat_out_valid_c%0d", k), {31'd0, out_valid}, {31'd0, (k == 4)});
        end
        check("wrap_sum", {15'd0, c_out, s}, 32'h0001_0000);
        check("done_in_ready", {31'd0, in_ready}, 32'd0);
        release_result();
        check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_in_ready",  {31'd0, in_ready},  32'd1);

        // Operand changes during RUN must not affect the captured values
        send_op(16'h1234, 16'h4321, 1'b1);
        a = 16'hFFFF; b = 16'hAAAA; c_in = 1'b0;
        tick();
        a = 16'h0F0F; b = 16'h5555;
        wait_result();
        check("capture_sum", {15'd0, c_out, s}, 32'h0000_5556);
        release_result();

        // DONE held 10 cycles with in_valid high: stable result, no accept
        check_op("hold_first", 16'hABCD, 16'h1111, 1'b0);
        held = {c_out, s};
        a = 16'h0F0F; b = 16'h0101; c_in = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_sum",       {15'd0, c_out, s}, {15'd0, held});
            check("hold_in_ready",  {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_exit_in_ready",  {31'd0, in_ready},  32'd1);
        check("hold_exit_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        check("hold_accept_in_ready", {31'd0, in_ready}, 32'd0);
        wait_result();
        check("hold_second_sum", {15'd0, c_out, s}, 32'h0000_1010);
        release_result();

        // Reset during the second RUN cycle aborts the op
        send_op(16'h00FF, 16'h0001, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_s",         {16'd0, s},         32'd0);
        check("abort_in_ready",  {31'd0, in_ready},  32'd1);
        for (int k = 0; k < 6; k++) tick();
        check("abort_no_result", {31'd0, out_valid}, 32'd0);
        check_op("after_abort", 16'h00FF, 16'h0001, 1'b0);
        release_result();

        // Signed-overflow style operands and carry-in at the top
        check_op("pos_ovf", 16'h7FFF, 16'h0000, 1'b1);
        release_result();
        check_op("neg_ovf", 16'h8000, 16'hFFFF, 1'b0);
        release_result();

        // Single-pass 8/8 instance
        a8 = 8'h7F; b8 = 8'h01; c_in8 = 1'b0; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick();
        check("w8_out_valid", {31'd0, out_valid8}, 32'd1);
        check("w8_sum",       {23'd0, c_out8, s8}, 32'h0000_0080);
`ifdef ADD_OVF_FLAG_EN
        check("w8_ovf",       {31'd0, ovf8},       32'd1);
`endif
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        check("w8_release", {31'd0, in_ready8}, 32'd1);

        // Randomised traffic with gaps on both sides
        fork
            begin : producer
                bit rdy;
                bit accepted;
                for (int i = 0; i < NRAND; i++) begin
                    int gap;
                    gap = int'($urandom_range(0, 3));
                    for (int g = 0; g < gap; g++) tick();
                    a        = 16'($urandom);
                    b        = 16'($urandom);
                    c_in     = 1'($urandom_range(0, 1));
                    in_valid = 1'b1;
                    accepted = 1'b0;
                    for (int k = 0; k < 60 && !accepted; k++) begin
                        rdy = in_ready;
                        tick();
                        if (rdy) accepted = 1'b1;
                    end
                    in_valid = 1'b0;
                    if (!accepted) begin
                        check("rand_accept_timeout", 32'd0, 32'd1);
                        break;
                    end
                    exp_sum_q.push_back({1'b0, a} + {1'b0, b} + {16'd0, c_in});
                    exp_ovf_q.push_back(ref_ovf16(a, b, c_in));
                end
            end
            begin : consumer
                int          got_cnt;
                bit          take;
                logic [16:0] got_sum;
                logic [16:0] want;
                bit          got_ovf;
                got_cnt = 0;
                got_ovf = 1'b0;
                for (int cyc = 0; cyc < NRAND * 40 && got_cnt < NRAND; cyc++) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    take      = out_valid && out_ready;
                    got_sum   = {c_out, s};
`ifdef ADD_OVF_FLAG_EN
                    got_ovf   = ovf;
`endif
                    tick();
                    if (take) begin
                        got_cnt++;
                        if (exp_sum_q.size() == 0) begin
                            check("rand_extra_result", 32'd1, 32'd0);
                        end else begin
                            want = exp_sum_q.pop_front();
                            check("rand_sum", {15'd0, got_sum}, {15'd0, want});
`ifdef ADD_OVF_FLAG_EN
                            check("rand_ovf", {31'd0, got_ovf}, {31'd0, exp_ovf_q.pop_front()});
`else
                            void'(exp_ovf_q.pop_front());
                            got_ovf = 1'b0;
`endif
                        end
                    end
                end
                out_ready = 1'b0;
                check("rand_count", got_cnt, NRAND);
            end
        join

        check("rand_leftover", exp_sum_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
